// File: rtl/rom_loader.sv
// rom_loader -- streams source beats into a contiguous address range of a
// write-only memory port.
//
// A load is requested with a start pulse carrying an inclusive address range
// [start_addr, end_addr]. Each beat accepted on the valid/ready handshake is
// written one cycle later to the next address in the range. The final write
// coincides with a one-cycle done pulse. An inverted range is rejected with a
// one-cycle err pulse, and abort cancels a load that is in progress.
//
// Optional feature: define ROM_LOADER_CKSUM_EN to add the cksum output. It
// holds the mod-2^DW sum of the words written by the current or most recent
// load.
//
// Ports
//   clk         : clock, all state changes on its rising edge
//   rst_n       : asynchronous active-low reset
//   start       : load request, sampled only while idle
//   start_addr  : first address to write (sampled with start)
//   end_addr    : last address to write, inclusive (sampled with start)
//   abort       : cancels an active load
//   in_valid    : source beat valid
//   in_data     : source beat data
//   in_ready    : loader accepts a beat this cycle
//   wr_en       : memory write strobe
//   wr_addr     : memory write address
//   wr_data     : memory write data
//   busy        : a load is active (LOAD or DONE)
//   done        : one-cycle pulse on the final write of a load
//   err         : one-cycle pulse when a request has start_addr > end_addr
//   cksum       : running sum of written data (ROM_LOADER_CKSUM_EN only)
module rom_loader #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
`ifdef ROM_LOADER_CKSUM_EN
  output logic          err,
  output logic [DW-1:0] cksum
`else
  output logic          err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] ptr_q,     ptr_d;
  logic [AW-1:0] last_q,    last_d;
  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          err_q,     err_d;
  logic          range_ok;
  logic          accept;

  assign range_ok = (start_addr <= end_addr);
  // abort takes priority over a coinciding handshake: the beat is dropped
  assign accept   = (state_q == LOAD) && in_valid && !abort;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (range_ok) begin
            state_d = LOAD;
            ptr_d   = start_addr;
            last_d  = end_addr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = in_data;
          // Stop on the last address instead of incrementing, so a full
          // 0..2^AW-1 load never wraps the pointer.
          if (ptr_q == last_q) begin
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      last_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  // Status is decoded from the state register. DONE is entered on the same
  // edge that registers the final write, so done lines up with that wr_en.
  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;

`ifdef ROM_LOADER_CKSUM_EN
  logic [DW-1:0] cksum_q, cksum_d;

  // The sum is accumulated at acceptance so it already includes the final
  // word during the done cycle. It then holds until the next valid start.
  always_comb begin
    cksum_d = cksum_q;
    if ((state_q == IDLE) && start && range_ok) begin
      cksum_d = '0;
    end else if (accept) begin
      cksum_d = cksum_q + in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] start_addr;
  logic [4:0] end_addr;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
`ifdef ROM_LOADER_CKSUM_EN
  logic [7:0] cksum;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rom_loader #(.DW(8), .AW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
`ifdef ROM_LOADER_CKSUM_EN
    .err        (err),
    .cksum      (cksum)
`else
    .err        (err)
`endif
  );

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  // Observed memory writes and status pulses, collected mid-cycle.
  wr_t        obs_q[$];
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         busy_cnt = 0;
  logic [4:0] done_addr = '0;
  logic       done_wr   = 1'b0;
  logic [7:0] done_ck   = '0;

  always @(negedge clk) begin
    if (wr_en) obs_q.push_back({wr_addr, wr_data});
    if (err)   err_cnt  = err_cnt + 1;
    if (busy)  busy_cnt = busy_cnt + 1;
    if (done) begin
      done_cnt  = done_cnt + 1;
      done_addr = wr_addr;
      done_wr   = wr_en;
`ifdef ROM_LOADER_CKSUM_EN
      done_ck   = cksum;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: data = destination address, valid every cycle
  // mode 1: random data, valid every other cycle
  // mode 2: random data, random valid
  // mode 3: data = 8'hA5, valid every cycle
  // abort_after >= 0: abort (together with a valid beat) once that many
  // beats have been accepted
  task automatic run_load(input logic [4:0] s, input logic [4:0] e,
                          input int mode, input int abort_after);
    wr_t        exp[$];
    int         ob = obs_q.size();
    int         dc = done_cnt;
    int         ec = err_cnt;
    int         bc = busy_cnt;
    int         n  = (s <= e) ? (int'(e) - int'(s) + 1) : 0;
    int         k  = 0;
    int         cyc = 0;
    bit         aborted = 0;
    bit         v;
    logic [7:0] d;
    logic [7:0] sum = '0;

    start = 1'b1; start_addr = s; end_addr = e;
    tick();
    start = 1'b0;
    start_addr = 5'($urandom); end_addr = 5'($urandom);

    while (k < n && cyc < 200) begin
      case (mode)
        0:       begin v = 1'b1;                       d = 8'(s) + 8'(k); end
        1:       begin v = (cyc % 2 == 0);             d = 8'($urandom);  end
        3:       begin v = 1'b1;                       d = 8'hA5;         end
        default: begin v = ($urandom_range(0, 3) != 0); d = 8'($urandom);  end
      endcase
      if (abort_after >= 0 && k == abort_after) begin
        abort = 1'b1; in_valid = 1'b1; in_data = d;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        aborted = 1'b1;
        break;
      end
      // a stray start in the middle of a load must be ignored
      start    = (cyc == 3);
      in_valid = v;
      in_data  = d;
      if (v) begin
        exp.push_back({s + 5'(k), d});
        sum = sum + d;
        k++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (!aborted) check("load_bound", k, n);

    // Beats offered after the load (DONE, then IDLE) must not be taken;
    // abort during DONE must not suppress done.
    for (int i = 0; i < 3; i++) begin
      abort    = (i == 0);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
    end
    abort = 1'b0; in_valid = 1'b0;
    tick(); tick();

    check("wr_count", obs_q.size() - ob, exp.size());
    for (int i = 0; i < exp.size() && (ob + i) < obs_q.size(); i++) begin
      check("wr_addr", obs_q[ob + i].a, exp[i].a);
      check("wr_data", obs_q[ob + i].d, exp[i].d);
    end
    check("done_pulses", done_cnt - dc, (n > 0 && !aborted) ? 1 : 0);
    check("err_pulses",  err_cnt - ec,  (n == 0) ? 1 : 0);
    if (n == 0) check("busy_on_err", busy_cnt - bc, 0);
    if (n > 0 && !aborted) begin
      check("done_addr", done_addr, e);
      check("done_with_wr", done_wr, 1'b1);
`ifdef ROM_LOADER_CKSUM_EN
      check("cksum_at_done", done_ck, sum);
`endif
    end
  endtask

  initial begin
    int dc;
    logic [4:0] a, b;

    rst_n = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0;
    abort = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wr_en",    wr_en,    1'b0);
    check("rst_wr_addr",  wr_addr,  5'd0);
    check("rst_wr_data",  wr_data,  8'd0);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_err",      err,      1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1'b0);

    // full range, data = address
    run_load(5'd0, 5'd31, 0, -1);
`ifdef ROM_LOADER_CKSUM_EN
    check("cksum_0_31", done_ck, 8'hF0);
`endif
    // gapped source
    run_load(5'd15, 5'd28, 1, -1);
    // inverted range
    run_load(5'h14, 5'h03, 2, -1);
    // single word
    run_load(5'd5, 5'd5, 3, -1);
    check("idle_after_single", busy, 1'b0);
    // abort after three beats, coinciding with a valid beat
    run_load(5'd0, 5'd31, 0, 3);
    check("idle_after_abort", busy, 1'b0);

    // reset in the middle of a load
    dc = done_cnt;
    start = 1'b1; start_addr = 5'd0; end_addr = 5'd31;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_wr_en",    wr_en,    1'b0);
    check("midrst_wr_addr",  wr_addr,  5'd0);
    check("midrst_wr_data",  wr_data,  8'd0);
    check("midrst_busy",     busy,     1'b0);
    check("midrst_done",     done,     1'b0);
    check("midrst_err",      err,      1'b0);
`ifdef ROM_LOADER_CKSUM_EN
    check("midrst_cksum",    cksum,    8'd0);
`endif
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    check("midrst_no_done", done_cnt - dc, 0);
    run_load(5'd9, 5'd12, 0, -1);

    // randomized loads
    for (int t = 0; t < 4; t++) begin
      a = 5'($urandom);
      b = 5'($urandom);
      if (a > b) run_load(b, a, 2, -1);
      else       run_load(a, b, 2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
